// File: rtl/data_top_pkg.sv
// Shared types and default sizing for the data_top req/ack transfer block.
// Optional macro DATA_TOP_SYNC_EN is consumed by data_top.
package data_top_pkg;

  localparam int DATA_W_DEF  = 4;
  localparam int MAX_VAL_DEF = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK_LOW
  } snd_state_t;

endpackage

// File: rtl/data_top_if.sv
// Observation bundle for data_top: captured payload plus handshake lines.
// master drives the bundle, slave watches it.
interface data_top_if
  import data_top_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              req;
  logic              ack;

  modport master (
    output data_out,
    output data_valid,
    output req,
    output ack
  );

  modport slave (
    input data_out,
    input data_valid,
    input req,
    input ack
  );

endinterface

// File: rtl/hs_sync_2ff.sv
// Two-flop single-bit synchronizer with synchronous active-high reset.
// Used for req/ack only when DATA_TOP_SYNC_EN is defined.
module hs_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // shift the async-domain bit through two flops
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/data_top.sv
// Sender and receiver joined by a four-phase req/ack handshake.
// Define DATA_TOP_SYNC_EN to insert two-flop synchronizers on req and ack.
module data_top
  import data_top_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              req,
  output logic              ack
);

  localparam logic [DATA_W-1:0] LAST = DATA_W'(MAX_VAL);
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

  snd_state_t        state;
  snd_state_t        state_n;
  logic              req_n;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] data_n;
  logic              req_s;
  logic              ack_s;

`ifdef DATA_TOP_SYNC_EN
  hs_sync_2ff u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req),
    .q   (req_s)
  );

  hs_sync_2ff u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack),
    .q   (ack_s)
  );
`else
  assign req_s = req;
  assign ack_s = ack;
`endif

  // sender state, request line and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      req   <= 1'b0;
      data  <= '0;
    end else begin
      state <= state_n;
      req   <= req_n;
      data  <= data_n;
    end
  end

  // sender next state; payload only advances once ack has dropped
  always_comb begin
    state_n = state;
    req_n   = req;
    data_n  = data;
    unique case (state)
      S_IDLE: begin
        req_n   = 1'b1;
        state_n = S_REQ;
      end
      S_REQ: begin
        if (ack_s) begin
          req_n   = 1'b0;
          state_n = S_ACK_LOW;
        end
      end
      S_ACK_LOW: begin
        if (!ack_s) begin
          data_n  = (data == LAST) ? '0 : data + ONE;
          state_n = S_IDLE;
        end
      end
      default: begin
        req_n   = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  // receiver: capture on rising req, release ack on falling req
  always_ff @(posedge clk) begin
    if (rst) begin
      ack        <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (req_s && !ack) begin
        data_out   <= data;
        data_valid <= 1'b1;
        ack        <= 1'b1;
      end else if (!req_s && ack) begin
        ack <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_top.sv
// Scoreboard bench for data_top: expected {edge, value} pairs are queued
// at stimulus time and popped as data_valid pulses appear.
module tb_data_top;

  localparam int DW = 4;
  localparam int MV = 7;
`ifdef DATA_TOP_SYNC_EN
  localparam int FIRST = 4;
  localparam int PER   = 13;
`else
  localparam int FIRST = 2;
  localparam int PER   = 5;
`endif

  typedef struct {
    int            edge_n;
    logic [DW-1:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  data_top_if #(.DATA_W(DW)) bus ();

  data_top #(
    .DATA_W  (DW),
    .MAX_VAL (MV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_out   (bus.data_out),
    .data_valid (bus.data_valid),
    .req        (bus.req),
    .ack        (bus.ack)
  );

  exp_t          vec [9];
  exp_t          sb [$];
  int            n_chk = 0;
  int            n_err = 0;
  int            cyc   = 0;
  logic          p_valid = 1'b0;
  logic          p_req   = 1'b0;
  logic          p_ack   = 1'b0;
  logic [DW-1:0] p_out   = '0;
  logic [DW-1:0] p_data  = '0;

  task automatic chk(input bit ok, input string name,
                     input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (rst) cyc = 0;
    else cyc++;
    if (!rst) begin
      if (bus.data_valid) begin
        chk(sb.size() != 0, "expected_pulse", 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk(cyc == e.edge_n, "pulse_edge", cyc, e.edge_n);
          chk(bus.data_out == e.val, "pulse_value",
              int'(bus.data_out), int'(e.val));
        end
        chk(!p_valid, "pulse_width", int'(p_valid), 0);
      end else begin
        chk(bus.data_out == p_out, "out_without_valid",
            int'(bus.data_out), int'(p_out));
      end
      chk(!(bus.req != p_req && bus.ack != p_ack),
          "req_ack_same_edge", 1, 0);
      chk(!(dut.data != p_data && (p_req || p_ack)),
          "data_stable", int'(dut.data), int'(p_data));
    end
    p_valid = bus.data_valid;
    p_req   = bus.req;
    p_ack   = bus.ack;
    p_out   = bus.data_out;
    p_data  = dut.data;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic chk_zero(input string name);
    chk(bus.req == 1'b0, {name, "_req"}, int'(bus.req), 0);
    chk(bus.ack == 1'b0, {name, "_ack"}, int'(bus.ack), 0);
    chk(bus.data_out == '0, {name, "_data_out"},
        int'(bus.data_out), 0);
    chk(bus.data_valid == 1'b0, {name, "_valid"},
        int'(bus.data_valid), 0);
  endtask

  task automatic drain(input string name, input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) tick();
    chk(sb.size() == 0, name, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 9; i++)
      vec[i] = '{FIRST + i * PER, DW'(i % (MV + 1))};

    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_zero("reset_hold");
    end

    rst = 1'b0;
    for (int i = 0; i < 9; i++) sb.push_back(vec[i]);
    drain("nine_transfers", FIRST + 8 * PER + 10);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) sb.push_back(vec[i]);
    drain("three_transfers", FIRST + 2 * PER + 10);
    chk(bus.ack == 1'b1, "ack_before_abort", int'(bus.ack), 1);

    rst = 1'b1;
    tick();
    chk_zero("abort");
    rst = 1'b0;
    for (int i = 0; i < 2; i++) sb.push_back(vec[i]);
    drain("restart", FIRST + PER + 10);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
